vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_sync_delay.sv | 48 ++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
//   - Default mode constants for 640x480@60 (25 MHz pixel) and 800x600@60 (40 MHz pixel)
//   - Sync polarity constants
//   - h_total()/v_total(): full line/frame length from the four region widths
package vga_timing_pkg;

  localparam logic SYNC_ACT_LO = 1'b0;
  localparam logic SYNC_ACT_HI = 1'b1;

  localparam int MAX_PIPE_DLY = 7;

  // 640x480@60
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;

  // 800x600@60
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;

  function automatic int h_total(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register of DEPTH stages, 3 bits wide, for {hsync, vsync, video_on}.
// Stages advance only when en is high; rst or clr load every stage with RST_VAL.
// DEPTH = 0 is a combinational pass-through.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - advance strobe (pixel tick)
//   clr  - synchronous clear to RST_VAL
//   d    - input bits
//   q    - output bits, DEPTH enabled cycles after d
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int         DEPTH   = 0,
  parameter logic [2:0] RST_VAL = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (DEPTH < 0 || DEPTH > MAX_PIPE_DLY) begin : g_depth_err
    $error("vga_sync_delay: DEPTH out of range 0..7");
  end

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en, clr};
    assign q = d;
  end else begin : g_sr
    logic [2:0] dly_p [DEPTH];

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        for (int i = 0; i < DEPTH; i++) dly_p[i] <= RST_VAL;
      end else if (en) begin
        dly_p[0] <= d;
        for (int i = 1; i < DEPTH; i++) dly_p[i] <= dly_p[i-1];
      end
    end

    assign q = dly_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator.
// An integer divider produces one pix_tick per CLK_DIV clocks; the column/row
// counters advance on pix_tick. Sync and video_on are decoded from the next
// count so they line up with px_x/px_y, then delayed PIPE_DLY pixel ticks to
// match downstream pixel-data latency. line_start/frame_start are not delayed.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   pix_tick     - one-clk strobe per pixel period
//   px_x, px_y   - current column/row (undelayed)
//   hsync, vsync - syncs with polarity HS_POL/VS_POL, delayed PIPE_DLY ticks
//   video_on     - active region flag, delayed PIPE_DLY ticks
//   line_start   - one-clk strobe when px_x loads 0 from a count wrap
//   frame_start  - one-clk strobe when px_x and px_y both load 0 from a wrap
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || CLK_DIV < 1) begin : g_param_err
    $error("vga_timing_gen: porch/sync widths and CLK_DIV must all be >= 1");
  end

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // A 1-bit divider counter is kept for CLK_DIV = 1 so the width is never zero.
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_cnt;
  logic          div_wrap;
  logic          x_wrap, y_wrap;
  logic [CW-1:0] x_nxt, y_nxt;
  logic          hs_on, vs_on, von_on;
  logic          hs_raw, vs_raw, von_raw;
  logic [2:0]    dly_q;

  assign div_wrap = (div_cnt == DIV_LAST);

  always_comb begin
    x_wrap = (px_x == H_LAST);
    y_wrap = (px_y == V_LAST);
    x_nxt  = px_x;
    y_nxt  = px_y;
    if (pix_tick) begin
      x_nxt = x_wrap ? '0 : px_x + CNT_ONE;
      if (x_wrap) y_nxt = y_wrap ? '0 : px_y + CNT_ONE;
    end
    hs_on  = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
    vs_on  = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    von_on = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  // Stage p0: divider, counters, strobes and raw decode registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_raw      <= ~HS_ACT;
      vs_raw      <= ~VS_ACT;
      von_raw     <= 1'b0;
    end else begin
      div_cnt     <= div_wrap ? '0 : div_cnt + DIV_ONE;
      pix_tick    <= div_wrap;
      px_x        <= x_nxt;
      px_y        <= y_nxt;
      line_start  <= pix_tick && x_wrap;
      frame_start <= pix_tick && x_wrap && y_wrap;
      hs_raw      <= hs_on ? HS_ACT : ~HS_ACT;
      vs_raw      <= vs_on ? VS_ACT : ~VS_ACT;
      von_raw     <= von_on;
    end
  end

  // Stage p1..pN: latency alignment of sync/video_on, advancing per pixel
  vga_sync_delay #(
    .DEPTH  (PIPE_DLY),
    .RST_VAL({~HS_ACT, ~VS_ACT, 1'b0})
  ) u_sync_delay (
    .clk(clk),
    .rst(rst),
    .en (pix_tick),
    .clr(1'b0),
    .d  ({hs_raw, vs_raw, von_raw}),
    .q  (dly_q)
  );

  assign {hsync, vsync, video_on} = dly_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Four instances share one clock:
//   a: default 640x480 mode, CLK_DIV 4, PIPE_DLY 0
//   b: small mode 8/1/2/1 x 4/1/1/1, CLK_DIV 4, PIPE_DLY 0
//   c: same as b but PIPE_DLY 3 (shares b's reset)
//   d: small mode, CLK_DIV 1, active-high syncs
module tb_vga_timing_gen;

  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_bc, rst_d;

  logic a_tick, a_hs, a_vs, a_von, a_ls, a_fs;
  logic b_tick, b_hs, b_vs, b_von, b_ls, b_fs;
  logic c_tick, c_hs, c_vs, c_von, c_ls, c_fs;
  logic d_tick, d_hs, d_vs, d_von, d_ls, d_fs;
  logic [CW-1:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .pix_tick(a_tick), .px_x(a_x), .px_y(a_y),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(4), .PIPE_DLY(0), .CW(CW)
  ) u_b (
    .clk(clk), .rst(rst_bc), .pix_tick(b_tick), .px_x(b_x), .px_y(b_y),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(4), .PIPE_DLY(3), .CW(CW)
  ) u_c (
    .clk(clk), .rst(rst_bc), .pix_tick(c_tick), .px_x(c_x), .px_y(c_y),
    .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .line_start(c_ls), .frame_start(c_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(1), .PIPE_DLY(0), .CW(CW)
  ) u_d (
    .clk(clk), .rst(rst_d), .pix_tick(d_tick), .px_x(d_x), .px_y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .line_start(d_ls), .frame_start(d_fs)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] outs(input int sel);
    case (sel)
      0:       return {a_hs, a_vs, a_von};
      1:       return {b_hs, b_vs, b_von};
      default: return {d_hs, d_vs, d_von};
    endcase
  endfunction

  function automatic logic [CW-1:0] cur_x(input int sel);
    case (sel)
      0:       return a_x;
      1:       return b_x;
      default: return d_x;
    endcase
  endfunction

  function automatic logic [CW-1:0] cur_y(input int sel);
    case (sel)
      0:       return a_y;
      1:       return b_y;
      default: return d_y;
    endcase
  endfunction

  task automatic wait_xy(input int sel, input int x, input int y, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (32'(cur_x(sel)) == x && 32'(cur_y(sel)) == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int   sel;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic von;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  logic [2:0] hist [16];

  initial begin
    bit         ok;
    int         n, k, n_act, n_hs, n_vs, perr, serr;
    logic [2:0] got;
    logic [CW-1:0] y0;
    logic       strobe;

    // default mode, active-low syncs
    vecs[0]  = '{0,   5, 0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{0, 639, 0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{0, 640, 0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{0, 655, 0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{0, 656, 0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{0, 751, 0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{0, 752, 0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{0, 799, 0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{0,   0, 1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{0, 100, 2, 1'b1, 1'b1, 1'b1};
    // small mode, CLK_DIV 1, active-high syncs: hs at x 9..10, vs at y 5
    vecs[10] = '{3,   7, 3, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3,   8, 3, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3,   9, 3, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3,  10, 3, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3,  11, 3, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3,   0, 4, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3,   5, 5, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3,   9, 5, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{3,   0, 6, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{3,   3, 0, 1'b0, 1'b0, 1'b1};
    // small mode, CLK_DIV 4, active-low syncs
    vecs[20] = '{1,   9, 5, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1,   2, 1, 1'b1, 1'b1, 1'b1};

    rst_a = 1'b1; rst_bc = 1'b1; rst_d = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_pix_tick",    32'(a_tick), 0);
    check("rst_px_x",        32'(a_x),    0);
    check("rst_px_y",        32'(a_y),    0);
    check("rst_hsync",       32'(a_hs),   1);
    check("rst_vsync",       32'(a_vs),   1);
    check("rst_video_on",    32'(a_von),  0);
    check("rst_line_start",  32'(a_ls),   0);
    check("rst_frame_start", 32'(a_fs),   0);
    check("rst_hsync_pol1",  32'(d_hs),   0);
    check("rst_vsync_pol1",  32'(d_vs),   0);
    check("rst_dly_hsync",   32'(c_hs),   1);
    check("rst_dly_von",     32'(c_von),  0);

    rst_a = 1'b0; rst_bc = 1'b0; rst_d = 1'b0;

    n = 0;
    do begin @(negedge clk); n++; end while (!a_tick && n < 20);
    check("first_tick_latency", 32'(n), 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!a_tick && n < 20);
    check("tick_period", 32'(n), 4);

    for (int i = 0; i < NVEC; i++) begin
      wait_xy(vecs[i].sel, vecs[i].x, vecs[i].y, ok);
      check($sformatf("vec%0d_reach", i), 32'(ok), 1);
      got = outs(vecs[i].sel);
      check($sformatf("vec%0d_hsync", i),    32'(got[2]), 32'(vecs[i].hs));
      check($sformatf("vec%0d_vsync", i),    32'(got[1]), 32'(vecs[i].vs));
      check($sformatf("vec%0d_video_on", i), 32'(got[0]), 32'(vecs[i].von));
    end

    // CLK_DIV = 1 keeps pix_tick high every clock
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!d_tick) n++;
    end
    check("div1_tick_lows", 32'(n), 0);

    // default mode: line length and line_start shape
    k = 0;
    while (!a_ls && k < 5000) begin @(negedge clk); k++; end
    check("a_ls_px_x", 32'(a_x), 0);
    check("a_ls_no_fs", 32'(a_fs), 0);
    y0 = a_y;
    @(negedge clk);
    check("a_ls_width", 32'(a_ls), 0);
    n = 0; k = 0;
    do begin @(negedge clk); k++; if (a_tick) n++; end while (!a_ls && k < 5000);
    check("a_line_ticks", 32'(n), 800);
    check("a_y_step", 32'(a_y), 32'(y0) + 1);

    // small mode: simultaneous wrap at (11,6)
    wait_xy(1, 11, 6, ok);
    check("b_reach_last", 32'(ok), 1);
    k = 0;
    while (b_x != 0 && k < 10) begin @(negedge clk); k++; end
    check("b_wrap_px_y", 32'(b_y), 0);
    check("b_wrap_fs",   32'(b_fs), 1);
    check("b_wrap_ls",   32'(b_ls), 1);
    @(negedge clk);
    check("b_fs_width", 32'(b_fs), 0);
    check("b_ls_width", 32'(b_ls), 0);

    // one full frame of b: ticks, active ticks, sync ticks
    n = 0; n_act = 0; n_hs = 0; n_vs = 0; k = 0;
    do begin
      @(negedge clk); k++;
      if (b_tick) begin
        n++;
        if (b_von) n_act++;
        if (!b_hs) n_hs++;
        if (!b_vs) n_vs++;
      end
    end while (!b_fs && k < 1000);
    check("b_frame_ticks",  32'(n),     84);
    check("b_active_ticks", 32'(n_act), 32);
    check("b_hsync_ticks",  32'(n_hs),  14);
    check("b_vsync_ticks",  32'(n_vs),  12);

    // line wrap without frame wrap
    wait_xy(1, 11, 2, ok);
    check("b_reach_11_2", 32'(ok), 1);
    k = 0;
    while (b_x != 0 && k < 10) begin @(negedge clk); k++; end
    check("b_line_ls", 32'(b_ls), 1);
    check("b_line_no_fs", 32'(b_fs), 0);
    check("b_line_px_y", 32'(b_y), 3);

    // CLK_DIV = 1 simultaneous wrap
    wait_xy(3, 11, 6, ok);
    check("d_reach_last", 32'(ok), 1);
    @(negedge clk);
    check("d_wrap_px", 32'({d_x, d_y}), 0);
    check("d_wrap_ls", 32'(d_ls), 1);
    check("d_wrap_fs", 32'(d_fs), 1);
    @(negedge clk);
    check("d_ls_width", 32'(d_ls), 0);
    check("d_fs_width", 32'(d_fs), 0);

    // PIPE_DLY 3 lags PIPE_DLY 0 by 3 pixel ticks (12 clocks); counters/strobes match
    perr = 0; serr = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      hist[t % 16] = {b_hs, b_vs, b_von};
      if (t >= 12 && {c_hs, c_vs, c_von} !== hist[(t - 12) % 16]) perr++;
      if ({c_x, c_y, c_ls, c_fs, c_tick} !== {b_x, b_y, b_ls, b_fs, b_tick}) serr++;
    end
    check("pipe_lag_errors", 32'(perr), 0);
    check("pipe_undelayed_errors", 32'(serr), 0);

    // reset mid-frame
    wait_xy(1, 5, 3, ok);
    check("b_reach_5_3", 32'(ok), 1);
    rst_bc = 1'b1;
    @(negedge clk);
    check("mid_rst_px", 32'({b_x, b_y}), 0);
    check("mid_rst_hsync", 32'(b_hs), 1);
    check("mid_rst_vsync", 32'(b_vs), 1);
    check("mid_rst_video_on", 32'(b_von), 0);
    check("mid_rst_strobes", 32'({b_ls, b_fs}), 0);
    check("mid_rst_tick", 32'(b_tick), 0);
    check("mid_rst_dly_hsync", 32'(c_hs), 1);
    rst_bc = 1'b0;
    n = 0; strobe = 1'b0;
    do begin
      @(negedge clk); n++;
      strobe = strobe | b_ls | b_fs;
    end while (!b_tick && n < 20);
    check("mid_rst_first_tick", 32'(n), 4);
    check("mid_rst_no_strobe", 32'(strobe), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
